// File: rtl/adc_serial_capture.sv
// adc_serial_capture: drives CS/SCLK of a serial ADC and captures 16-bit frames.
// Ports: clk, rst (async active-low), sample_tick, sdata -> cs_n, sclk, sample[11:0],
//        sample_valid (1-cycle pulse), overrun (1-cycle pulse on a dropped request).
module adc_serial_capture #(
    parameter int SCLK_HALF = 4,
    parameter int QUIET_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        sdata,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    localparam logic [12:0] SETUP_LAST = 13'(SCLK_HALF - 1);
    localparam logic [12:0] SHIFT_LAST = 13'(32 * SCLK_HALF - 1);
    localparam logic [12:0] QUIET_LAST = 13'(QUIET_CYC - 1);
    localparam logic [7:0]  HALF_LAST  = 8'(SCLK_HALF - 1);

    state_t      state;
    logic        tick_q;
    logic        rise;
    logic [12:0] cnt;
    logic [7:0]  hc;
    logic [15:0] shift;

    assign rise = sample_tick & ~tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tick_q       <= 1'b1;
            cnt          <= '0;
            hc           <= '0;
            shift        <= '0;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            tick_q       <= sample_tick;
            sample_valid <= 1'b0;
            // requests are never queued: any rise outside IDLE is dropped
            overrun      <= rise && (state != IDLE);
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= SETUP;
                        cs_n  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= SHIFT;
                        sclk  <= 1'b0;
                        cnt   <= '0;
                        hc    <= '0;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        // sclk is already high here after its 16th rise
                        state        <= DONE;
                        cs_n         <= 1'b1;
                        sample       <= shift[11:0];
                        sample_valid <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 13'd1;
                        if (hc == HALF_LAST) begin
                            hc   <= '0;
                            sclk <= ~sclk;
                            // capture on the low->high sclk transition
                            if (!sclk) begin
                                shift <= (shift << 1) | 16'(sdata);
                            end
                        end else begin
                            hc <= hc + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= QUIET;
                    cnt   <= '0;
                end
                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed bench with a frame-level timing model
// checked every cycle, plus literal expectations on key frames.
module tb_adc_serial_capture;

    localparam int H = 2;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic        sdata = 1'b0;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        overrun;

    always #5 clk = ~clk;

    adc_serial_capture #(.SCLK_HALF(H), .QUIET_CYC(Q)) dut (
        .clk(clk),
        .rst(rst),
        .sample_tick(sample_tick),
        .sdata(sdata),
        .cs_n(cs_n),
        .sclk(sclk),
        .sample(sample),
        .sample_valid(sample_valid),
        .overrun(overrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // n: index of the last clk edge seen out of reset.
    // e0: edge 0 of the most recently accepted frame (-1: none).
    int          n = 0;
    int          e0 = -1;
    int          k;
    logic        tprev = 1'b1;
    logic        rise_m;
    logic        idle_m;
    logic [11:0] cap = '0;
    logic [11:0] smp_e = '0;
    logic        val_e = 1'b0;
    logic        ovr_e = 1'b0;
    logic [15:0] word = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0    = -1;
            tprev = 1'b1;
            smp_e = '0;
            val_e = 1'b0;
            ovr_e = 1'b0;
        end else begin
            n      = n + 1;
            rise_m = sample_tick && !tprev;
            tprev  = sample_tick;
            val_e  = 1'b0;
            ovr_e  = 1'b0;
            idle_m = 1'b1;
            if (e0 >= 0) begin
                k = n - e0;
                if (k > 0 && k % (2 * H) == 0 && k <= 32 * H)
                    cap = {cap[10:0], sdata};
                if (k == 33 * H) begin
                    smp_e = cap;
                    val_e = 1'b1;
                end
                // back in IDLE for the whole cycle ending at this edge
                idle_m = (k >= 33 * H + Q + 2);
            end
            if (rise_m) begin
                if (idle_m) e0 = n;
                else ovr_e = 1'b1;
            end
        end
    end

    // ADC data: correct bit at each capture edge, random elsewhere
    int dk;
    always @(negedge clk) begin
        dk = n + 1 - e0;
        if (e0 >= 0 && dk > 0 && dk % (2 * H) == 0 && dk <= 32 * H)
            sdata = word[16 - dk / (2 * H)];
        else
            sdata = 1'($urandom_range(0, 1));
    end

    // ---------------- per-cycle compare + event counters ----------------
    int   mk;
    logic cs_e, sclk_e;
    int   n_rise = 0, n_val = 0, n_ovr = 0, val_edge = 0;
    logic sclk_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        mk     = n - e0;
        cs_e   = !(e0 >= 0 && mk < 33 * H);
        sclk_e = !(e0 >= 0 && mk >= H && mk < 33 * H && ((mk / H) % 2 == 1));
        chk("cyc_cs_n", 32'(cs_n), 32'(cs_e));
        chk("cyc_sclk", 32'(sclk), 32'(sclk_e));
        chk("cyc_sample", 32'(sample), 32'(smp_e));
        chk("cyc_valid", 32'(sample_valid), 32'(val_e));
        chk("cyc_overrun", 32'(overrun), 32'(ovr_e));
        if (sclk && !sclk_prev) n_rise++;
        sclk_prev = sclk;
        if (sample_valid) begin
            n_val++;
            val_edge = n;
        end
        if (overrun) n_ovr++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick_pulse();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_to(input int e);
        int lim = 2000;
        while (n < e && lim > 0) begin
            @(negedge clk);
            lim--;
        end
        if (n < e) chk("wait_timeout", 32'(n), 32'(e));
    endtask

    int ef, v0, r0, o0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_sample", 32'(sample), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // single frame 0000_1010_0101_1100
        word = 16'h0A5C;
        v0 = n_val; r0 = n_rise;
        ef = n + 1;
        tick_pulse();
        chk("t1_cs_low", 32'(cs_n), 32'd0);
        wait_to(ef + 66);
        chk("t1_valid_now", 32'(sample_valid), 32'd1);
        chk("t1_valid_edge", 32'(val_edge - ef), 32'd66);
        chk("t1_sample", 32'(sample), 32'hA5C);
        chk("t1_cs_high", 32'(cs_n), 32'd1);
        chk("t1_sclk_rises", 32'(n_rise - r0), 32'd16);
        wait_to(ef + 80);
        chk("t1_one_valid", 32'(n_val - v0), 32'd1);

        // second request at edge 20 is dropped
        word = 16'h1234;
        v0 = n_val; o0 = n_ovr;
        ef = n + 1;
        tick_pulse();
        wait_to(ef + 19);
        tick_pulse();
        wait_to(ef + 80);
        chk("t2_overrun", 32'(n_ovr - o0), 32'd1);
        chk("t2_valid", 32'(n_val - v0), 32'd1);
        chk("t2_sample", 32'(sample), 32'h234);

        // rise in final QUIET cycle: dropped, no frame
        word = 16'h0FFF;
        v0 = n_val; o0 = n_ovr;
        ef = n + 1;
        tick_pulse();
        wait_to(ef + 70);
        tick_pulse();
        wait_to(ef + 76);
        chk("t3_overrun", 32'(n_ovr - o0), 32'd1);
        chk("t3_no_frame", 32'(cs_n), 32'd1);
        chk("t3_valid", 32'(n_val - v0), 32'd1);

        // rise one cycle after returning to IDLE starts a frame
        word = 16'hF321;
        o0 = n_ovr;
        ef = n + 1;
        tick_pulse();
        wait_to(ef + 71);
        tick_pulse();
        chk("t3b_cs_low", 32'(cs_n), 32'd0);
        chk("t3b_no_overrun", 32'(n_ovr - o0), 32'd0);
        wait_to(ef + 72 + 80);
        chk("t3b_sample", 32'(sample), 32'h321);

        // async reset at edge 30 of a frame
        word = 16'hABCD;
        v0 = n_val;
        ef = n + 1;
        tick_pulse();
        wait_to(ef + 30);
        chk("t4_sclk_low_before", 32'(sclk), 32'd0);
        rst = 1'b0;
        #1;
        chk("t4_cs_n", 32'(cs_n), 32'd1);
        chk("t4_sclk", 32'(sclk), 32'd1);
        chk("t4_sample", 32'(sample), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        chk("t4_no_valid", 32'(n_val - v0), 32'd0);
        word = 16'h5A5A;
        ef = n + 1;
        tick_pulse();
        wait_to(ef + 80);
        chk("t4_clean_sample", 32'(sample), 32'hA5A);
        chk("t4_clean_valid", 32'(n_val - v0), 32'd1);

        // release reset with sample_tick already high
        sample_tick = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_no_start", 32'(cs_n), 32'd1);
        sample_tick = 1'b0;
        @(negedge clk);
        word = 16'h0C3A;
        ef = n + 1;
        tick_pulse();
        chk("t5_start", 32'(cs_n), 32'd0);
        wait_to(ef + 80);
        chk("t5_sample", 32'(sample), 32'hC3A);

        // free-running tick, period 200: no drops
        word = 16'h0777;
        v0 = n_val; o0 = n_ovr;
        for (int i = 0; i < 600; i++) begin
            sample_tick = ((i % 200) < 100);
            @(negedge clk);
        end
        sample_tick = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_p200_valid", 32'(n_val - v0), 32'd3);
        chk("t6_p200_ovr", 32'(n_ovr - o0), 32'd0);

        // period 60: every second request dropped
        v0 = n_val; o0 = n_ovr;
        for (int i = 0; i < 360; i++) begin
            sample_tick = ((i % 60) < 30);
            @(negedge clk);
        end
        sample_tick = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_p60_valid", 32'(n_val - v0), 32'd3);
        chk("t6_p60_ovr", 32'(n_ovr - o0), 32'd3);
        chk("t6_sample", 32'(sample), 32'h777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_serial_capture.md
ADC_SERIAL_CAPTURE -- requirements
Module: adc_serial_capture

Interface
REQ-001 The parameter SCLK_HALF SHALL default to 4: the SCLK half-period in clk cycles; legal range is 1..255.
REQ-002 The parameter QUIET_CYC SHALL default to 4: the minimum number of clk cycles cs_n stays high between frames; legal range is 1..255.
REQ-003 The block SHALL have one clock, `clk`, input, 1 bit: all state updates on its rising edge.
REQ-004 The block SHALL have the reset `rst`, input, 1 bit: asynchronous, active-low.
REQ-005 `sample_tick`, input, 1 bit, SHALL be the divided clock from the upstream divider; it is synchronous to clk, and each rising edge requests one conversion.
REQ-006 `sdata`, input, 1 bit, SHALL be the serial data from the ADC, MSB first.
REQ-007 `cs_n`, output, 1 bit, SHALL be the ADC chip select, active-low.
REQ-008 `sclk`, output, 1 bit, SHALL be the ADC serial clock, idling high.
REQ-009 `sample`, output, 12 bits, SHALL hold the last completed conversion result.
REQ-010 `sample_valid`, output, 1 bit, SHALL be a one-cycle pulse marking a new `sample`.
REQ-011 `overrun`, output, 1 bit, SHALL be a one-cycle pulse marking a dropped request.

Function
REQ-012 The block SHALL register `sample_tick` into `tick_q` every cycle and define rise = `sample_tick` & ~`tick_q`.
REQ-013 The FSM SHALL use these states and transitions:
- IDLE -> SETUP on rise.
- SETUP -> SHIFT after SCLK_HALF cycles.
- SHIFT -> DONE after 32*SCLK_HALF cycles.
- DONE -> QUIET after 1 cycle.
- QUIET -> IDLE after QUIET_CYC cycles.
REQ-014 Timing SHALL be referenced to edge 0, the clk edge at the end of the cycle in which rise is high while in IDLE; `cs_n` SHALL go low at edge 0.
REQ-015 `sclk` SHALL stay high during IDLE, SETUP, DONE and QUIET.
REQ-016 For j=0..15, `sclk` SHALL fall at edge (2j+1)*SCLK_HALF and rise at edge (2j+2)*SCLK_HALF.
REQ-017 At each clk edge where `sclk` goes low->high, `sdata` SHALL be shifted into the LSB of a 16-bit shift register, giving exactly 16 captures per frame.
REQ-018 At edge 33*SCLK_HALF (entry to DONE), the block SHALL:
- drive `cs_n` high;
- load `sample` <= shift[11:0], ignoring the 4 leading bits;
- drive `sample_valid` high for exactly one cycle.
REQ-019 `sample` SHALL hold its value until the next DONE.
REQ-020 A rise in SETUP, SHIFT, DONE or QUIET SHALL be dropped and SHALL pulse `overrun` high on the following cycle; the frame in progress continues unaffected.
REQ-021 A rise in the final QUIET cycle SHALL be dropped; requests are never queued.
REQ-022 A rise that coincides with entry to IDLE SHALL be accepted only if the FSM is already in IDLE during that cycle.
REQ-023 All counters SHALL be sized for 32*255 and SHALL never wrap within a frame.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 While `rst`=0, regardless of state, the block SHALL force:
- FSM = IDLE;
- `cs_n`=1, `sclk`=1;
- `sample`=12'h000, `sample_valid`=0, `overrun`=0;
- shift register = 0, counters = 0;
- `tick_q`=1.
REQ-026 Assertion of `rst` mid-frame SHALL abort the frame immediately (asynchronously), with no `sample_valid` pulse.
REQ-027 Because `tick_q` resets to 1, a `sample_tick` that is high at reset release SHALL NOT start a conversion; the next genuine rising edge SHALL start one.

Verification
REQ-028 With SCLK_HALF=2 and QUIET_CYC=4, a single rise and `sdata` frame 0000_1010_0101_1100 SHALL produce:
- `cs_n` low at edge 0;
- 16 `sclk` rises, at edges 4, 8, ..., 64;
- `sample_valid` high for the single cycle after edge 66;
- `sample`=12'hA5C;
- `cs_n` high at edge 66.
REQ-029 A second rise at edge 20 of a frame SHALL pulse `overrun` once, and the frame SHALL still complete with the correct `sample` and exactly one `sample_valid`.
REQ-030 A rise in the final QUIET cycle SHALL raise `overrun`, and no frame SHALL start.
REQ-031 A rise one cycle after returning to IDLE SHALL start a frame normally.
REQ-032 `rst`=0 pulsed at edge 30 of a frame SHALL immediately force `cs_n`=1, `sclk`=1 and `sample`=0, with no `sample_valid`; after release, the next rise SHALL start a clean frame.
REQ-033 Releasing `rst` while `sample_tick`=1 SHALL start no frame until `sample_tick` goes 0->1.
REQ-034 A free-running `sample_tick` with period 200 clk cycles SHALL produce one `sample_valid` per period with `overrun` never asserted; a period of 60 cycles SHALL produce alternating drops, each flagged by `overrun`.
